// File: rtl/lfsr_equiv_sched.sv
// lfsr_equiv_sched: drives one pseudo-random bit stream into a Fibonacci/Galois
// LFSR pair and counts the shifts where their output bits disagree.
// FSM: IDLE -> RUN -> REPORT -> IDLE.
// Optional build macro LFSR_SCHED_TIMEOUT_EN adds a stall watchdog in RUN that
// reports with err=1; without it RUN waits for the LFSRs indefinitely.
//
// Handshake: a transfer on any X__ENA/X__RDY pair happens in the cycle where
// both are high. start is accepted only when start__RDY=1. abort has no ready.
// result_v is held stable while result__ENA=1 until result__RDY is seen.
module lfsr_equiv_sched #(
  parameter int            LN   = 8,
  parameter logic [LN-1:0] TAPS = 45,
  parameter int            CNTW = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start__ENA,
  input  logic [LN+CNTW-1:0]   start_v,
  output logic                 start__RDY,
  input  logic                 abort__ENA,
  output logic                 lfsr_shiftBit__ENA,
  output logic                 lfsr_shiftBit_v,
  input  logic                 fib_shiftBit__RDY,
  input  logic                 gal_shiftBit__RDY,
  input  logic                 fib_outBit,
  input  logic                 gal_outBit,
  output logic                 result__ENA,
  output logic [2*CNTW+1:0]    result_v,
  input  logic                 result__RDY,
  output logic [1:0]           dbgState
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  state_t          state, stateNext;
  logic [LN-1:0]   pat;
  logic [CNTW-1:0] remaining, shiftIdx, mismatches, firstIdx;
  logic            sat, err;

  logic [LN-1:0]   seed;
  logic [CNTW-1:0] runLen;
  logic            startAcc, shiftEn, lastShift, timeout;

  assign seed      = start_v[LN+CNTW-1:CNTW];
  assign runLen    = start_v[CNTW-1:0];
  assign startAcc  = start__ENA && (state == IDLE);
  assign shiftEn   = (state == RUN) && fib_shiftBit__RDY && gal_shiftBit__RDY;
  assign lastShift = shiftEn && (remaining == CNTW'(1));

`ifdef LFSR_SCHED_TIMEOUT_EN
  logic [7:0] stallCnt;
  logic       stalled;

  assign stalled = (state == RUN) && !(fib_shiftBit__RDY && gal_shiftBit__RDY);
  // the 255th consecutive stall cycle ends the run
  assign timeout = stalled && (stallCnt == 8'd254);

  // count consecutive RUN cycles in which either LFSR refuses a shift
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      stallCnt <= 8'd0;
    else if (startAcc || shiftEn) stallCnt <= 8'd0;
    else if (stalled)             stallCnt <= stallCnt + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= stateNext;
  end

  // next-state logic; a shift coincident with abort still completes below
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start__ENA) stateNext = (runLen == '0) ? REPORT : RUN;
      RUN:     if (lastShift || abort__ENA || timeout) stateNext = REPORT;
      REPORT:  if (result__RDY) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // run datapath: pattern generator, counters and result fields
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pat        <= '0;
      remaining  <= '0;
      shiftIdx   <= '0;
      mismatches <= '0;
      firstIdx   <= '0;
      sat        <= 1'b0;
      err        <= 1'b0;
    end else if (startAcc) begin
      pat        <= (seed == '0) ? LN'(1) : seed;
      remaining  <= runLen;
      shiftIdx   <= '0;
      mismatches <= '0;
      firstIdx   <= CNT_MAX;
      sat        <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (shiftEn) begin
        pat       <= {^(pat & TAPS), pat[LN-1:1]};
        remaining <= remaining - CNTW'(1);
        shiftIdx  <= shiftIdx + CNTW'(1);
        if (fib_outBit != gal_outBit) begin
          if (mismatches != CNT_MAX) begin
            mismatches <= mismatches + CNTW'(1);
            if (mismatches == CNT_MAX - CNTW'(1)) sat <= 1'b1;
          end
          if (firstIdx == CNT_MAX) firstIdx <= shiftIdx;
        end
      end
      if (timeout) err <= 1'b1;
    end
  end

  // outputs
  always_comb begin
    start__RDY         = (state == IDLE);
    lfsr_shiftBit__ENA = shiftEn;
    lfsr_shiftBit_v    = pat[0];
    result__ENA        = (state == REPORT);
    result_v           = {err, sat, mismatches, firstIdx};
    dbgState           = state;
  end

endmodule

// File: tb/tb_lfsr_equiv_sched.sv
// tb_lfsr_equiv_sched: randomized and directed runs of lfsr_equiv_sched against
// a cycle-schedule reference model; a negedge monitor scores every shifted bit
// and every presented result against expected queues.
module tb_lfsr_equiv_sched;

  localparam int            LN   = 8;
  localparam logic [LN-1:0] TAPS = 8'd45;
  localparam int            CNTW = 16;
  localparam int            RW   = 2*CNTW+2;
  localparam int            MAXC = 400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start_ena, start_rdy, abort_ena;
  logic [LN+CNTW-1:0] start_v;
  logic              shift_ena, shift_v;
  logic              fib_rdy, gal_rdy, fib_out, gal_out;
  logic              result_ena, result_rdy;
  logic [RW-1:0]     result_v;
  logic [1:0]        dbg_state;

  lfsr_equiv_sched #(.LN(LN), .TAPS(TAPS), .CNTW(CNTW)) dut (
    .CLK(clk), .RST(rst),
    .start__ENA(start_ena), .start_v(start_v), .start__RDY(start_rdy),
    .abort__ENA(abort_ena),
    .lfsr_shiftBit__ENA(shift_ena), .lfsr_shiftBit_v(shift_v),
    .fib_shiftBit__RDY(fib_rdy), .gal_shiftBit__RDY(gal_rdy),
    .fib_outBit(fib_out), .gal_outBit(gal_out),
    .result__ENA(result_ena), .result_v(result_v), .result__RDY(result_rdy),
    .dbgState(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic          exp_bit_q[$];
  logic [RW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int ena_seen = 0;

  // per-cycle schedule of LFSR behaviour, index = cycles after start acceptance
  logic fr_a[MAXC], gr_a[MAXC], fo_a[MAXC], go_a[MAXC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: score each shift strobe and each presented result
  always @(negedge clk) begin
    if (!rst) begin
      if (shift_ena) begin
        ena_seen++;
        if (exp_bit_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_shift: got bit %0b expected no shift (t=%0t)", shift_v, $time);
        end else begin
          check("shift_bit", 64'(shift_v), 64'(exp_bit_q.pop_front()));
        end
      end
      if (result_ena) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got %0h expected none (t=%0t)", result_v, $time);
        end else begin
          check("result", 64'(result_v), 64'(exp_q[0]));
          if (result_rdy) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Walks the schedule: every cycle where both LFSRs are ready is one shift.
  // The pattern generator advances as value/2 plus the tap parity in the MSB.
  task automatic model_run(input logic [LN-1:0] seed, input int n, input int abort_c,
                           output int n_shift, output int end_c);
    logic [LN-1:0] p;
    int mism, first, idx, rem;
    logic sat;
    p = (seed == 0) ? LN'(1) : seed;
    mism = 0; first = 65535; idx = 0; rem = n; sat = 0;
    n_shift = 0; end_c = 0;
    if (n > 0) begin
      for (int c = 1; c < MAXC; c++) begin
        if (fr_a[c] && gr_a[c]) begin
          exp_bit_q.push_back(p[0]);
          if (fo_a[c] != go_a[c]) begin
            if (mism < 65535) mism++;
            if (mism == 65535) sat = 1;
            if (first == 65535) first = idx;
          end
          p = LN'(p / 2 + 128 * ($countones(p & TAPS) % 2));
          idx++; rem--; n_shift++;
        end
        if (rem == 0 || c == abort_c) begin
          end_c = c;
          break;
        end
      end
    end
    exp_q.push_back({1'b0, sat, 16'(mism), 16'(first)});
  endtask

  // mode 0: equal outputs, 1: inverted, 2: random
  task automatic sched_fill(input int rdy_pct, input int mode);
    for (int c = 0; c < MAXC; c++) begin
      fr_a[c] = ($urandom_range(99) < rdy_pct) || (c > 200);
      gr_a[c] = ($urandom_range(99) < rdy_pct) || (c > 200);
      fo_a[c] = 1'($urandom_range(1));
      case (mode)
        0:       go_a[c] = fo_a[c];
        1:       go_a[c] = !fo_a[c];
        default: go_a[c] = 1'($urandom_range(1));
      endcase
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset_check();
    rst = 1'b1;
    #1;
    check("rst_start_rdy",  64'(start_rdy),  64'd1);
    check("rst_shift_ena",  64'(shift_ena),  64'd0);
    check("rst_shift_v",    64'(shift_v),    64'd0);
    check("rst_result_ena", 64'(result_ena), 64'd0);
    check("rst_result_v",   64'(result_v),   64'd0);
    check("rst_state_idle", 64'(dbg_state),  64'd0);
    exp_bit_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic issue_start(input logic [LN-1:0] seed, input int n);
    check("start_rdy_idle", 64'(start_rdy), 64'd1);
    start_ena = 1'b1;
    start_v   = {seed, 16'(n)};
    @(posedge clk); #1;
    start_ena = 1'b0;
  endtask

  task automatic run_one(input logic [LN-1:0] seed, input int n, input int abort_c, input int hold);
    int n_shift, end_c, c;
    model_run(seed, n, abort_c, n_shift, end_c);
    ena_seen = 0;
    issue_start(seed, n);
    c = 1;
    while (!result_ena && c < MAXC) begin
      fib_rdy = fr_a[c]; gal_rdy = gr_a[c];
      fib_out = fo_a[c]; gal_out = go_a[c];
      abort_ena = (c == abort_c);
      @(posedge clk); #1;
      c++;
    end
    abort_ena = 1'b0; fib_rdy = 1'b1; gal_rdy = 1'b1;
    check("result_ena", 64'(result_ena), 64'd1);
    check("run_cycles", 64'(c - 1), 64'(end_c));
    check("shift_count", 64'(ena_seen), 64'(n_shift));
    for (int i = 0; i < hold; i++) begin
      start_ena = 1'b1;
      start_v   = 24'($urandom);
      @(posedge clk); #1;
      check("start_rdy_report", 64'(start_rdy), 64'd0);
    end
    start_ena = 1'b0;
    result_rdy = 1'b1;
    @(posedge clk); #1;
    result_rdy = 1'b0;
    check("idle_after_ack", 64'(start_rdy), 64'd1);
    check("res_q_drained", 64'(exp_q.size()), 64'd0);
    check("bit_q_drained", 64'(exp_bit_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    start_ena = 1'b0; start_v = '0; abort_ena = 1'b0;
    fib_rdy = 1'b1; gal_rdy = 1'b1; fib_out = 1'b0; gal_out = 1'b0;
    result_rdy = 1'b0;
    @(posedge clk); #1;
    do_reset_check();

    // equal outputs, seed 1, N=16
    sched_fill(100, 0);
    run_one(8'h01, 16, -1, 0);

    // inverted outputs, N=10: every shift mismatches, first at index 0
    sched_fill(100, 1);
    run_one(8'h01, 10, -1, 1);

    // fib ready low for three cycles mid-run, N=8
    sched_fill(100, 0);
    for (int c = 3; c <= 5; c++) fr_a[c] = 1'b0;
    run_one(8'h5A, 8, -1, 0);

    // N=0: result next cycle, held through 5 cycles of back-pressure
    sched_fill(100, 2);
    run_one(8'h33, 0, -1, 5);

    // seed 0 behaves as seed 1
    sched_fill(100, 1);
    run_one(8'h00, 12, -1, 0);

    // abort coincident with the 5th shift of N=100
    sched_fill(100, 1);
    run_one(8'h01, 100, 5, 2);

    // reset in the middle of a run
    begin
      int ns, ec;
      sched_fill(100, 2);
      model_run(8'hC3, 50, -1, ns, ec);
      issue_start(8'hC3, 50);
      for (int c = 1; c <= 6; c++) begin
        fib_out = fo_a[c]; gal_out = go_a[c];
        @(posedge clk); #1;
      end
      do_reset_check();
    end

    // randomized runs
    for (int r = 0; r < 12; r++) begin
      int ab;
      sched_fill(70, 2);
      ab = ($urandom_range(4) == 0) ? int'($urandom_range(30, 1)) : -1;
      run_one(8'($urandom_range(255)), int'($urandom_range(40)), ab, int'($urandom_range(3)));
    end

    // gal ready held low for 300 cycles
    begin
      int c;
      ena_seen = 0;
`ifdef LFSR_SCHED_TIMEOUT_EN
      exp_q.push_back({1'b1, 1'b0, 16'd0, 16'hFFFF});
`endif
      issue_start(8'h01, 4);
      gal_rdy = 1'b0;
      c = 0;
      while (!result_ena && c < 300) begin
        @(posedge clk); #1;
        c++;
      end
      gal_rdy = 1'b1;
      check("stall_no_shift", 64'(ena_seen), 64'd0);
`ifdef LFSR_SCHED_TIMEOUT_EN
      check("timeout_cycles", 64'(c), 64'd255);
      check("timeout_result", 64'(result_ena), 64'd1);
      result_rdy = 1'b1;
      @(posedge clk); #1;
      result_rdy = 1'b0;
      check("timeout_idle", 64'(start_rdy), 64'd1);
`else
      check("stall_no_result", 64'(result_ena), 64'd0);
      check("stall_still_run", 64'(dbg_state), 64'd1);
      do_reset_check();
`endif
    end

    // back to normal operation after all of the above
    sched_fill(80, 2);
    run_one(8'h81, 20, -1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
